seq_divu_r2: RTL and testbench
==============================

// Module: seq_divu_r2
// PURPOSE
//   Multi-cycle unsigned radix-2 restoring divider. It is the responder side of the
//   start/busy/done/valid handshake the ALU uses to issue DIV/DIVU/REM/REMU.
//   The ALU supplies pre-computed magnitudes and applies sign fix-up itself.
//   This block only divides unsigned operands and holds the result until the next start.
// PARAMETERS
//   WIDTH  32  operand, quotient and remainder width (>=4, power of two)
// PORTS
//   clk_i        in   1      clock, all state updates on rising edge
//   rst_ni       in   1      asynchronous active-low reset
//   start_i      in   1      request; accepted only when busy_o==0
//   dividend_i   in   WIDTH  dividend, sampled on the accepting edge only
//   divisor_i    in   WIDTH  divisor, sampled on the accepting edge only
//   busy_o       out  1      iteration in progress
//   done_o       out  1      one-cycle pulse, result just became valid
//   valid_o      out  1      quotient_o/reminder_o/dbz_o hold a valid result
//   dbz_o        out  1      last accepted divisor was zero (qualified by valid_o)
//   quotient_o   out  WIDTH  unsigned quotient
//   reminder_o   out  WIDTH  unsigned remainder
// BEHAVIOUR
// - Reset (async, rst_ni=0): state IDLE. busy_o, done_o, valid_o and dbz_o are 0.
//   quotient_o and reminder_o are 0. Counter and work registers are cleared.
//   Reset mid-operation aborts the division. No result and no done_o are produced.
// - FSM states (package enum div_state_e): DIV_IDLE and DIV_CALC.
//   - DIV_IDLE -> DIV_CALC when start_i is high and divisor is non-zero.
//   - DIV_CALC stays while the counter is non-zero.
//   - DIV_CALC -> DIV_IDLE when the last iteration completes.
// - Accepting edge:
//   - Captures the operands and clears valid_o and dbz_o.
//   - Loads rem = 0, quo = dividend and cnt = WIDTH.
// - Each DIV_CALC edge performs one step:
//   - t = {rem, quo[WIDTH-1]} - {1'b0, divisor}, computed WIDTH+1 bits wide.
//   - If t is non-negative: rem = t[WIDTH-1:0] and quo = {quo[WIDTH-2:0], 1}.
//   - Otherwise: rem = {rem[WIDTH-2:0], quo[WIDTH-1]} and quo = {quo[WIDTH-2:0], 0}.
//   - cnt decrements by 1.
// - Latency with start_i high in cycle 0:
//   - busy_o is high in cycles 1..WIDTH.
//   - done_o pulses in cycle WIDTH+1 and valid_o rises in the same cycle.
//   - busy_o is low in cycle WIDTH+1.
// - Divide by zero (divisor 0 on the accepting edge):
//   - No iterations run and busy_o never rises.
//   - In cycle 1: done_o=1, valid_o=1, dbz_o=1, quotient_o='1, reminder_o=dividend.
//   - These values match RISC-V semantics.
// - Result hold: valid_o and all results stay stable until the next accepted start.
//   Input changes do not affect a held result.
// - start_i while busy_o=1 is ignored. The operation in flight is unaffected.
// - start_i in the done_o cycle is accepted (busy_o is already 0):
//   - valid_o falls next cycle and the new operation begins.
//   - The ALU relies on this for back-to-back ops.
// - done_o never stays high for 2 consecutive cycles.
// CONFIGURATION
// - TCORE_DIV_EARLY_TERM_EN defined:
//   - The accepting edge computes n = clz(dividend).
//   - It preloads quo = dividend << n and cnt = WIDTH-n.
//   - Latency becomes WIDTH-n+1 cycles to done_o.
//   - Dividend 0 (n=WIDTH): no iterations. done_o is in cycle 1 with quotient 0 and remainder 0.
//   - Divide-by-zero handling is unchanged.
// - Macro undefined: fixed WIDTH iterations and no leading-zero counter logic.
//   Results are bit-identical in both builds.
// STRUCTURE
// - tcore_param package holds:
//   - div_state_e {DIV_IDLE, DIV_CALC}.
//   - DIV_CNT_W = $clog2(WIDTH)+1.
// - One sub-module, lzc (parameter WIDTH):
//   - Combinational leading-zero count, output $clog2(WIDTH)+1 bits.
//   - Instantiated only under TCORE_DIV_EARLY_TERM_EN.
// - The datapath is one WIDTH+1 subtractor plus rem/quo/cnt registers. No multiplier.
// TESTING (WIDTH=32)
// - 100/7, start in cycle 0 -> done_o pulses in cycle 33, quotient 14, remainder 2, dbz_o=0.
// - 5/0 -> done_o in cycle 1, busy_o never high, quotient 0xFFFFFFFF, remainder 5, dbz_o=1.
// - 0xFFFFFFFF/1, then start 0x80000000/0xFFFFFFFF in the done_o cycle:
//   - First result: quotient 0xFFFFFFFF, remainder 0.
//   - valid_o falls the next cycle.
//   - Second result: quotient 0, remainder 0x80000000.
// - Start 1000/10, pulse start_i with 9/3 in cycle 5 -> second start ignored; result 100, remainder 0.
// - Start 1000/10, assert rst_ni=0 in cycle 10 -> all outputs 0 immediately. No done_o after release.
// - EARLY_TERM_EN:
//   - 3/1 -> done_o in cycle 3, quotient 3, remainder 0.
//   - 0/9 -> done_o in cycle 1, quotient 0, remainder 0.
//   - Randomised results match the non-EN build.

Source files
------------

// File: rtl/seq_divu_r2_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
package tcore_param;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_CALC = 1'b1
    } div_state_e;

    // Counter width must hold the value WIDTH itself, hence the extra bit.
    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/seq_divu_r2_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module lzc
    import tcore_param::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]             i_data,
    output logic [div_cnt_w(WIDTH)-1:0]  o_cnt
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    // Ascending scan: the highest set bit is the last one to overwrite.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/seq_divu_r2.sv
// Multi-cycle unsigned radix-2 restoring divider with start/busy/done/valid handshake.
// Optional leading-zero skip enabled by defining TCORE_DIV_EARLY_TERM_EN.
module seq_divu_r2
    import tcore_param::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] reminder_o
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       r_state, w_state_next;
    logic [WIDTH-1:0] r_rem, w_rem_next;
    logic [WIDTH-1:0] r_quo, w_quo_next;
    logic [WIDTH-1:0] r_divisor, w_divisor_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_done, w_done_next;
    logic             r_valid, w_valid_next;
    logic             r_dbz, w_dbz_next;

    logic [WIDTH-1:0] w_quo_init;
    logic [CNT_W-1:0] w_cnt_init;
    logic [WIDTH:0]   w_t;

`ifdef TCORE_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] w_lz;

    lzc #(.WIDTH(WIDTH)) u_lzc (
        .i_data (dividend_i),
        .o_cnt  (w_lz)
    );

    // Leading zeros would only shift zero quotient bits in; skip them up front.
    assign w_quo_init = dividend_i << w_lz;
    assign w_cnt_init = CNT_W'(WIDTH) - w_lz;
`else
    assign w_quo_init = dividend_i;
    assign w_cnt_init = CNT_W'(WIDTH);
`endif

    assign w_t = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_divisor};

    always_comb begin
        w_state_next   = r_state;
        w_rem_next     = r_rem;
        w_quo_next     = r_quo;
        w_divisor_next = r_divisor;
        w_cnt_next     = r_cnt;
        w_done_next    = 1'b0;
        w_valid_next   = r_valid;
        w_dbz_next     = r_dbz;
        case (r_state)
            DIV_IDLE: begin
                if (start_i) begin
                    w_divisor_next = divisor_i;
                    w_valid_next   = 1'b0;
                    w_dbz_next     = 1'b0;
                    w_cnt_next     = '0;
                    if (divisor_i == '0) begin
                        w_quo_next   = '1;
                        w_rem_next   = dividend_i;
                        w_done_next  = 1'b1;
                        w_valid_next = 1'b1;
                        w_dbz_next   = 1'b1;
                    end else if (w_cnt_init == '0) begin
                        w_quo_next   = '0;
                        w_rem_next   = '0;
                        w_done_next  = 1'b1;
                        w_valid_next = 1'b1;
                    end else begin
                        w_quo_next   = w_quo_init;
                        w_rem_next   = '0;
                        w_cnt_next   = w_cnt_init;
                        w_state_next = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (!w_t[WIDTH]) begin
                    w_rem_next = w_t[WIDTH-1:0];
                    w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_next = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                    w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
                end
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = DIV_IDLE;
                    w_done_next  = 1'b1;
                    w_valid_next = 1'b1;
                end
            end
            default: w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= DIV_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_divisor <= w_divisor_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_done_next;
            r_valid   <= w_valid_next;
            r_dbz     <= w_dbz_next;
        end
    end

    assign busy_o     = (r_state == DIV_CALC);
    assign done_o     = r_done;
    assign valid_o    = r_valid;
    assign dbz_o      = r_dbz;
    assign quotient_o = r_quo;
    assign reminder_o = r_rem;

endmodule

// File: tb/tb_seq_divu_r2.sv
// Self-checking bench for seq_divu_r2 (WIDTH=32); works with or without TCORE_DIV_EARLY_TERM_EN.
module tb_seq_divu_r2;

    localparam int W = 32;

    logic         clk;
    logic         rst_ni;
    logic         start_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         busy_o;
    logic         done_o;
    logic         valid_o;
    logic         dbz_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] reminder_o;

    int checks = 0;
    int failures = 0;

    seq_divu_r2 #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .valid_o    (valid_o),
        .dbz_o      (dbz_o),
        .quotient_o (quotient_o),
        .reminder_o (reminder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic plus the documented latency rules.
    function automatic logic [W-1:0] ref_quo(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        int bits;
        logic [W-1:0] v;
        if (b == 0) return 1;
`ifdef TCORE_DIV_EARLY_TERM_EN
        bits = 0;
        v = a;
        while (v != 0) begin
            v = v >> 1;
            bits++;
        end
        return (bits == 0) ? 1 : bits + 1;
`else
        v = a;
        bits = 0;
        return W + 1 + bits + int'(v & 0);
`endif
    endfunction

    // Raise start for one cycle; returns positioned 1 time unit into cycle 1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Advance until done_o, counting cycles since the accepting edge; -1 on timeout.
    task automatic wait_done(input int first, output int lat, output bit busy_seen);
        lat = first;
        busy_seen = 1'b0;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) busy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (done_o !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        start_i = 1'b0;
        dividend_i = '0;
        divisor_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, valid_o, dbz_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {busy_o, done_o, valid_o, dbz_o});
        end
        checks++;
        if (quotient_o !== '0 || reminder_o !== '0) begin
            failures++;
            $display("FAIL reset_results got q=%h r=%h want 0/0", quotient_o, reminder_o);
        end
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released");
    endtask

    task automatic test_directed;
        logic [W-1:0] tab_a [4] = '{32'd100, 32'd5, 32'd3, 32'd0};
        logic [W-1:0] tab_b [4] = '{32'd7, 32'd0, 32'd1, 32'd9};
        int lat;
        bit bs;
        for (int i = 0; i < 4; i++) begin
            start_op(tab_a[i], tab_b[i]);
            wait_done(1, lat, bs);
            $display("directed %0d/%0d: lat=%0d q=%h r=%h dbz=%b", tab_a[i], tab_b[i],
                     lat, quotient_o, reminder_o, dbz_o);
            checks++;
            if (lat != ref_lat(tab_a[i], tab_b[i])) begin
                failures++;
                $display("FAIL dir_latency got=%0d want=%0d", lat, ref_lat(tab_a[i], tab_b[i]));
            end
            checks++;
            if (quotient_o !== ref_quo(tab_a[i], tab_b[i]) || reminder_o !== ref_rem(tab_a[i], tab_b[i])) begin
                failures++;
                $display("FAIL dir_result got q=%h r=%h want q=%h r=%h", quotient_o, reminder_o,
                         ref_quo(tab_a[i], tab_b[i]), ref_rem(tab_a[i], tab_b[i]));
            end
            checks++;
            if (dbz_o !== (tab_b[i] == 0) || valid_o !== 1'b1 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL dir_flags got dbz=%b valid=%b busy=%b want dbz=%b valid=1 busy=0",
                         dbz_o, valid_o, busy_o, tab_b[i] == 0);
            end
            checks++;
            if (bs !== (ref_lat(tab_a[i], tab_b[i]) > 1)) begin
                failures++;
                $display("FAIL dir_busy_seen got=%b want=%b", bs, ref_lat(tab_a[i], tab_b[i]) > 1);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done_o !== 1'b0 || valid_o !== 1'b1) begin
                failures++;
                $display("FAIL dir_done_pulse got done=%b valid=%b want done=0 valid=1", done_o, valid_o);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit bs;
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, bs);
        checks++;
        if (quotient_o !== 32'hFFFF_FFFF || reminder_o !== 32'd0 || lat != ref_lat(32'hFFFF_FFFF, 32'd1)) begin
            failures++;
            $display("FAIL b2b_first got q=%h r=%h lat=%0d want q=ffffffff r=0 lat=%0d",
                     quotient_o, reminder_o, lat, ref_lat(32'hFFFF_FFFF, 32'd1));
        end
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_valid_fall got valid=%b busy=%b want valid=0 busy=1", valid_o, busy_o);
        end
        wait_done(1, lat, bs);
        $display("b2b second: lat=%0d q=%h r=%h", lat, quotient_o, reminder_o);
        checks++;
        if (quotient_o !== 32'd0 || reminder_o !== 32'h8000_0000 || lat != ref_lat(32'h8000_0000, 32'hFFFF_FFFF)) begin
            failures++;
            $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=0 r=80000000 lat=%0d",
                     quotient_o, reminder_o, lat, ref_lat(32'h8000_0000, 32'hFFFF_FFFF));
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        bit bs;
        start_op(32'd1000, 32'd10);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_op(32'd9, 32'd3);
        wait_done(6, lat, bs);
        $display("ignore_start: lat=%0d q=%0d r=%0d", lat, quotient_o, reminder_o);
        checks++;
        if (quotient_o !== 32'd100 || reminder_o !== 32'd0 || lat != ref_lat(32'd1000, 32'd10)) begin
            failures++;
            $display("FAIL ignore_start got q=%0d r=%0d lat=%0d want q=100 r=0 lat=%0d",
                     quotient_o, reminder_o, lat, ref_lat(32'd1000, 32'd10));
        end
    endtask

    task automatic test_reset_mid;
        int done_cnt = 0;
        start_op(32'd1000, 32'd10);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, valid_o, dbz_o} !== 4'b0000 || quotient_o !== '0 || reminder_o !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got flags=%b q=%h r=%h want all 0",
                     {busy_o, done_o, valid_o, dbz_o}, quotient_o, reminder_o);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1 || valid_o === 1'b1) done_cnt++;
        end
        $display("reset_mid: done/valid cycles after release=%0d", done_cnt);
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d want=0", done_cnt);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, hq, hr;
        int lat;
        bit bs;
        for (int n = 0; n < 40; n++) begin
            a = $urandom >> $urandom_range(0, W);
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = $urandom >> $urandom_range(0, W - 1);
                default: b = $urandom;
            endcase
            start_op(a, b);
            wait_done(1, lat, bs);
            $display("rand %h/%h: lat=%0d q=%h r=%h dbz=%b", a, b, lat, quotient_o, reminder_o, dbz_o);
            checks++;
            if (lat != ref_lat(a, b) || quotient_o !== ref_quo(a, b) || reminder_o !== ref_rem(a, b)
                || dbz_o !== (b == 0) || valid_o !== 1'b1) begin
                failures++;
                $display("FAIL rand_op got lat=%0d q=%h r=%h dbz=%b valid=%b want lat=%0d q=%h r=%h dbz=%b valid=1",
                         lat, quotient_o, reminder_o, dbz_o, valid_o,
                         ref_lat(a, b), ref_quo(a, b), ref_rem(a, b), b == 0);
            end
            hq = ref_quo(a, b);
            hr = ref_rem(a, b);
            repeat ($urandom_range(1, 3)) begin
                dividend_i = $urandom;
                divisor_i = $urandom;
                @(posedge clk);
                #1;
            end
            checks++;
            if (quotient_o !== hq || reminder_o !== hr || valid_o !== 1'b1 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL rand_hold got q=%h r=%h valid=%b done=%b want q=%h r=%h valid=1 done=0",
                         quotient_o, reminder_o, valid_o, done_o, hq, hr);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
